mux_stream_rr: RTL and testbench
================================

Name: mux_stream_rr

Overview:
- Parametrised registered N-to-1 stream multiplexer; successor to the 4-channel, 4-bit combinational selector.
- Each channel has a valid/ready handshake; the output is one register stage.
- Two selection modes:
  - Direct: external select.
  - Round-robin: fair arbitration across valid channels.
- Sits between multiple producers and a single downstream consumer.

Parameters:
- NUM_CH, 4, number of input channels; must be >= 2.
- DATA_W, 4, data width per channel in bits.
- SEL_W, derived localparam = $clog2(NUM_CH), width of select and channel-ID fields.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = direct select, 1 = round-robin.
- sel  input  SEL_W  channel index, used only when mode = 0.
- in_data  input  NUM_CH*DATA_W  flat bus; channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  input  NUM_CH  per-channel valid.
- in_last  input  NUM_CH  per-channel end-of-packet; used only with MUX_PKT_LOCK_EN.
- in_ready  output  NUM_CH  per-channel ready; at most one bit high per cycle.
- out_data  output  DATA_W  registered selected data.
- out_ch  output  SEL_W  index of the channel that produced out_data.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - out_valid = 0, out_data = 0, out_ch = 0.
  - Round-robin pointer rr_last = NUM_CH-1, so channel 0 has first priority.
  - Lock state cleared.
- load_en = !out_valid || out_ready. Output register accepts a beat only when load_en = 1.
- Grant is combinational from in_valid, mode, sel, rr_last and lock. in_ready[i] = load_en && grant[i]. grant is one-hot or zero.
- Transfer on channel i: in_valid[i] && in_ready[i]. At that clock edge:
  - out_data <= channel i data, out_ch <= i, out_valid <= 1.
- Latency is 1 cycle from input transfer to out_valid.
- Full throughput: one beat per cycle while out_ready = 1 and some grant exists.
- If load_en = 1 and there is no grant, out_valid <= 0 at the edge. out_data and out_ch hold their last values.
- Stall: when out_valid && !out_ready, out_data, out_ch and out_valid are frozen, and all in_ready = 0.
- Direct mode (mode = 0):
  - grant[sel] = in_valid[sel].
  - sel >= NUM_CH (non-power-of-2 NUM_CH) gives no grant; this is not an error.
  - rr_last is not updated.
- Round-robin mode (mode = 1):
  - Search order is rr_last+1, rr_last+2, … modulo NUM_CH, wrapping from NUM_CH-1 to 0.
  - The first channel in that order with in_valid = 1 is granted.
  - rr_last <= granted index, only on a transfer.
  - A single requester is granted every cycle.
  - Idle cycles do not move the pointer.
- Mode or sel change:
  - Takes effect in the same cycle's grant.
  - Never alters a beat already held in the output register.
- Handshake rules:
  - Producers must hold in_valid and in_data stable until the transfer.
  - The block never asserts in_ready for a channel whose in_valid = 0.
- Reset mid-operation: the held beat is discarded and out_valid drops immediately (asynchronous).

Optional Feature:
- Macro: MUX_PKT_LOCK_EN.
- Defined:
  - After a transfer from channel i with in_last[i] = 0, grant is locked to i, in both modes, until a transfer from i with in_last[i] = 1.
  - While locked, other channels get in_ready = 0 even if channel i deasserts valid.
  - rr_last updates per beat as normal.
  - Reset clears the lock.
- Undefined: in_last is ignored, there is no lock state, and arbitration is per beat.

Test Plan:
- Reset: rst_n = 0 mid-stream with out_valid = 1 -> out_valid = 0, out_data = 0, out_ch = 0 without waiting for a clock edge; first round-robin grant after release goes to ch0.
- Direct mode: mode = 0, sel = 2, in_valid = 4'b1111, ch2 data = 4'hA, out_ready = 1 -> in_ready = 4'b0100; next cycle out_data = 4'hA, out_ch = 2.
- Round-robin fairness: mode = 1, in_valid = 4'b1111 held, out_ready = 1 for 8 cycles -> out_ch sequence 0, 1, 2, 3, 0, 1, 2, 3, one beat per cycle.
- Back-pressure: out_ready = 0 for 3 cycles with out_valid = 1 -> out_data and out_ch frozen, in_ready = 0000; when out_ready = 1 resumes, the next grant follows rr_last+1 with no beat lost or duplicated.
- Sparse and wrap: mode = 1, rr_last = 3, in_valid = 4'b1010 -> ch1 granted, then ch3, then ch1; in_valid = 0000 -> out_valid drops after the pending beat drains.
- MUX_PKT_LOCK_EN: ch0 sends 3 beats with in_last = 0, 0, 1 while ch1 is valid throughout -> all 3 ch0 beats are output consecutively, then ch1. Without the macro, the beats interleave 0, 1, 0, 1.

Source files
------------

// File: rtl/mux_stream_rr_if.sv
// Stream-mux bus: per-channel input handshakes, select controls and the single output stream.
// The master side is the producers/consumer environment; the slave side is the multiplexer.
interface mux_stream_rr_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 4
);
    localparam int SEL_W = $clog2(NUM_CH);

    logic                     mode;
    logic [SEL_W-1:0]         sel;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_last;
    logic [NUM_CH-1:0]        in_ready;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         out_ch;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output mode, sel, in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/mux_stream_rr.sv
// Registered N-to-1 stream multiplexer with direct-select and round-robin modes.
// Optional packet lock (keep the grant on one channel until in_last) under `define MUX_PKT_LOCK_EN.
module mux_stream_rr #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 4
) (
    input logic            clk,
    input logic            rst_n,
    mux_stream_rr_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_CH);

    logic                  load_en;
    logic [NUM_CH-1:0]     arb_grant;
    logic [NUM_CH-1:0]     grant;
    logic                  gnt_any;
    logic [SEL_W-1:0]      gnt_idx;
    logic [DATA_W-1:0]     gnt_data;
    logic                  gnt_last;
    logic                  xfer;

    logic [DATA_W-1:0]     out_data_q,  out_data_d;
    logic [SEL_W-1:0]      out_ch_q,    out_ch_d;
    logic                  out_valid_q, out_valid_d;
    logic [SEL_W-1:0]      rr_last_q,   rr_last_d;

    // The output register can take a new beat when empty or being drained this cycle.
    assign load_en = !out_valid_q || bus.out_ready;

    always_comb begin
        logic found;
        int   idx;
        arb_grant = '0;
        found     = 1'b0;
        idx       = 0;
        if (!bus.mode) begin
            for (int i = 0; i < NUM_CH; i++) begin
                arb_grant[i] = bus.in_valid[i] && (bus.sel == SEL_W'(i));
            end
        end else begin
            // Search starts one past the last granted channel, wrapping to 0.
            for (int k = 1; k <= NUM_CH; k++) begin
                idx = (int'(rr_last_q) + k) % NUM_CH;
                if (!found && bus.in_valid[idx]) begin
                    arb_grant[idx] = 1'b1;
                    found          = 1'b1;
                end
            end
        end
    end

`ifdef MUX_PKT_LOCK_EN
    logic             lock_q,    lock_d;
    logic [SEL_W-1:0] lock_ch_q, lock_ch_d;

    // While a packet is open only its channel may be granted, regardless of mode.
    always_comb begin
        grant = arb_grant;
        if (lock_q) begin
            for (int i = 0; i < NUM_CH; i++) begin
                grant[i] = bus.in_valid[i] && (lock_ch_q == SEL_W'(i));
            end
        end
    end

    always_comb begin
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
        if (xfer) begin
            lock_d    = !gnt_last;
            lock_ch_d = gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
        end
    end
`else
    logic unused_in_last;

    assign grant          = arb_grant;
    assign unused_in_last = ^bus.in_last;
`endif

    always_comb begin
        gnt_any  = |grant;
        gnt_idx  = '0;
        gnt_data = '0;
        gnt_last = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                gnt_idx  = SEL_W'(i);
                gnt_data = bus.in_data[i*DATA_W +: DATA_W];
                gnt_last = bus.in_last[i];
            end
        end
    end

    assign xfer         = load_en && gnt_any;
    assign bus.in_ready = load_en ? grant : '0;

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        rr_last_d   = rr_last_q;
        if (load_en) begin
            out_valid_d = gnt_any;
        end
        if (xfer) begin
            out_data_d = gnt_data;
            out_ch_d   = gnt_idx;
            if (bus.mode) begin
                rr_last_d = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            rr_last_q   <= SEL_W'(NUM_CH - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            rr_last_q   <= rr_last_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_mux_stream_rr.sv
// Directed self-checking bench for mux_stream_rr (NUM_CH = 4, DATA_W = 4).
module tb_mux_stream_rr;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    mux_stream_rr_if #(.NUM_CH(4), .DATA_W(4)) bus ();

    mux_stream_rr #(.NUM_CH(4), .DATA_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int exp_seq [4];
        int beat0;
        n_vec         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        bus.mode      = 1'b0;
        bus.sel       = '0;
        bus.in_data   = 16'h3A5C;   // ch3=3, ch2=A, ch1=5, ch0=C
        bus.in_valid  = 4'b0000;
        bus.in_last   = 4'b1111;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_valid", 32'(bus.out_valid), 32'h0);
        check_eq("rst_data",  32'(bus.out_data),  32'h0);
        check_eq("rst_ch",    32'(bus.out_ch),    32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Direct select of ch2 with every channel requesting.
        bus.mode     = 1'b0;
        bus.sel      = 2'd2;
        bus.in_valid = 4'b1111;
        #1 check_eq("dir_ready", 32'(bus.in_ready), 32'h4);
        step();
        check_eq("dir_data",  32'(bus.out_data),  32'hA);
        check_eq("dir_ch",    32'(bus.out_ch),    32'h2);
        check_eq("dir_valid", 32'(bus.out_valid), 32'h1);

        // Round-robin with all valid: pointer still 3, so 0,1,2,3,0,1,2,3.
        bus.mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1 check_eq($sformatf("rr_ready%0d", i), 32'(bus.in_ready), 32'(1 << (i % 4)));
            step();
            check_eq($sformatf("rr_ch%0d", i),    32'(bus.out_ch),    32'(i % 4));
            check_eq($sformatf("rr_valid%0d", i), 32'(bus.out_valid), 32'h1);
        end
        check_eq("rr_data_last", 32'(bus.out_data), 32'h3);

        // Back-pressure: ch3 beat held for 3 cycles, then ch0 next.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check_eq($sformatf("bp_ready%0d", i), 32'(bus.in_ready), 32'h0);
            step();
            check_eq($sformatf("bp_ch%0d", i),   32'(bus.out_ch),   32'h3);
            check_eq($sformatf("bp_data%0d", i), 32'(bus.out_data), 32'h3);
            check_eq($sformatf("bp_vld%0d", i),  32'(bus.out_valid), 32'h1);
        end
        bus.out_ready = 1'b1;
        #1 check_eq("bp_resume_ready", 32'(bus.in_ready), 32'h1);
        step();
        check_eq("bp_resume_ch",   32'(bus.out_ch),   32'h0);
        check_eq("bp_resume_data", 32'(bus.out_data), 32'hC);

        // Only ch3 requests: pointer moves to 3.
        bus.in_valid = 4'b1000;
        #1 check_eq("sp_ready3", 32'(bus.in_ready), 32'h8);
        step();
        check_eq("sp_ch3", 32'(bus.out_ch), 32'h3);

        // Sparse 1010 from rr_last = 3: ch1, ch3, ch1.
        bus.in_valid = 4'b1010;
        #1 check_eq("sp_ready_a", 32'(bus.in_ready), 32'h2);
        step();
        check_eq("sp_ch_a",   32'(bus.out_ch),   32'h1);
        check_eq("sp_data_a", 32'(bus.out_data), 32'h5);
        #1 check_eq("sp_ready_b", 32'(bus.in_ready), 32'h8);
        step();
        check_eq("sp_ch_b", 32'(bus.out_ch), 32'h3);
        #1 check_eq("sp_ready_c", 32'(bus.in_ready), 32'h2);
        step();
        check_eq("sp_ch_c", 32'(bus.out_ch), 32'h1);

        // Drain: no requesters, pending beat leaves and out_valid drops.
        bus.in_valid = 4'b0000;
        #1 check_eq("drain_ready",  32'(bus.in_ready),  32'h0);
        check_eq("drain_pending", 32'(bus.out_valid), 32'h1);
        step();
        check_eq("drain_valid", 32'(bus.out_valid), 32'h0);
        check_eq("drain_data",  32'(bus.out_data),  32'h5);
        check_eq("drain_ch",    32'(bus.out_ch),    32'h1);

        // Direct select of an idle channel gives no grant; then a same-cycle sel change.
        bus.mode     = 1'b0;
        bus.sel      = 2'd1;
        bus.in_valid = 4'b1101;
        #1 check_eq("dir_idle_ready", 32'(bus.in_ready), 32'h0);
        step();
        check_eq("dir_idle_valid", 32'(bus.out_valid), 32'h0);
        bus.sel = 2'd3;
        #1 check_eq("dir_sel3_ready", 32'(bus.in_ready), 32'h8);
        step();
        check_eq("dir_sel3_ch", 32'(bus.out_ch), 32'h3);

        // Packet test: rr_last = 1 (direct mode did not move it), ch0 and ch1 both valid.
`ifdef MUX_PKT_LOCK_EN
        exp_seq = '{0, 0, 0, 1};
`else
        exp_seq = '{0, 1, 0, 1};
`endif
        bus.mode     = 1'b1;
        bus.in_valid = 4'b0011;
        beat0        = 0;
        for (int i = 0; i < 4; i++) begin
            bus.in_data[3:0] = 4'(beat0 + 1);
            bus.in_last[0]   = (beat0 == 2);
            #1 check_eq($sformatf("pkt_ready%0d", i), 32'(bus.in_ready), 32'(1 << exp_seq[i]));
            step();
            check_eq($sformatf("pkt_ch%0d", i),   32'(bus.out_ch),   32'(exp_seq[i]));
            check_eq($sformatf("pkt_data%0d", i), 32'(bus.out_data),
                     (exp_seq[i] == 0) ? 32'(beat0 + 1) : 32'h5);
            if (exp_seq[i] == 0) beat0++;
        end
        bus.in_last = 4'b1111;

        // Asynchronous reset with a beat held: outputs clear before any clock edge.
        check_eq("mid_valid_before", 32'(bus.out_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1 check_eq("arst_valid", 32'(bus.out_valid), 32'h0);
        check_eq("arst_data", 32'(bus.out_data), 32'h0);
        check_eq("arst_ch",   32'(bus.out_ch),   32'h0);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_data  = 16'h3A5C;
        bus.in_valid = 4'b1111;
        #1 check_eq("post_rst_ready", 32'(bus.in_ready), 32'h1);
        step();
        check_eq("post_rst_ch",   32'(bus.out_ch),   32'h0);
        check_eq("post_rst_data", 32'(bus.out_data), 32'hC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
